// File: rtl/dm_bytelane_if.sv
// Load/store port of the byte-lane data memory: address, store data, access mode, trace PC.
// The master drives the request; the slave returns extended load data, misalign and busy.
interface dm_bytelane_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic [2:0]  mode;
  logic [31:0] pc;
  logic [31:0] rdata;
  logic        misalign;
  logic        busy;

  modport master (output addr, wdata, we, mode, pc, input rdata, misalign, busy);
  modport slave  (input addr, wdata, we, mode, pc, output rdata, misalign, busy);
endinterface

// File: rtl/dm_bytelane.sv
// MIPS data memory with word/half/byte lanes, sign/zero-extended loads and a post-reset clear sweep.
// Read is combinational (READ_LAT=0) or registered one cycle (READ_LAT=1); busy during the sweep blocks access.
module dm_bytelane #(
  parameter int ADDR_W   = 10,
  parameter int READ_LAT = 0,
  parameter int TRACE    = 1
) (
  input logic           clk,
  input logic           reset,
  dm_bytelane_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
  logic [31:0]         mem [DEPTH];

  logic [ADDR_W-1:0]   idx;
  logic [31:0]         rd_word;
  logic                busy;
  logic                is_half, is_byte, is_signed;
  logic                mis_raw;
  logic                store_ok;
  logic [31:0]         merged;
  logic [31:0]         rdata_c;
  logic                misalign_c;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_wa;
  logic [31:0]         mem_wd;

  assign idx     = bus.addr[ADDR_W+1:2];
  assign rd_word = mem[idx];
  assign busy    = (state_q == CLEAR);
  assign bus.busy = busy;

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    if (reset) begin
      state_d   = CLEAR;
      clr_ptr_d = '0;
    end else if (state_q == CLEAR) begin
      clr_ptr_d = clr_ptr_q + 1'b1;
      if (&clr_ptr_q) state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    state_q   <= state_d;
    clr_ptr_q <= clr_ptr_d;
  end

  // Undefined modes 101-111 fall through to word accesses.
  always_comb begin
    is_half   = (bus.mode == 3'b001) || (bus.mode == 3'b010);
    is_byte   = (bus.mode == 3'b011) || (bus.mode == 3'b100);
    is_signed = (bus.mode == 3'b010) || (bus.mode == 3'b100);
    if (is_byte)      mis_raw = 1'b0;
    else if (is_half) mis_raw = bus.addr[0];
    else              mis_raw = (bus.addr[1:0] != 2'b00);
  end

  assign store_ok = !reset && !busy && bus.we && !mis_raw;

  always_comb begin
    merged = rd_word;
    if (is_half)      merged[{bus.addr[1], 4'b0000} +: 16] = bus.wdata[15:0];
    else if (is_byte) merged[{bus.addr[1:0], 3'b000} +: 8] = bus.wdata[7:0];
    else              merged = bus.wdata;
  end

  always_comb begin
    mem_we = 1'b0;
    mem_wa = idx;
    mem_wd = merged;
    if (!reset) begin
      if (busy) begin
        mem_we = 1'b1;
        mem_wa = clr_ptr_q;
        mem_wd = '0;
      end else if (store_ok) begin
        mem_we = 1'b1;
      end
    end
  end

  // Single write port, no reset on the array, so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  always_comb begin
    logic [15:0] half;
    logic [7:0]  byte_v;
    half       = bus.addr[1] ? rd_word[31:16] : rd_word[15:0];
    byte_v     = rd_word[{bus.addr[1:0], 3'b000} +: 8];
    misalign_c = !busy && mis_raw;
    if (busy || mis_raw)  rdata_c = '0;
    else if (is_half)     rdata_c = {{16{is_signed & half[15]}}, half};
    else if (is_byte)     rdata_c = {{24{is_signed & byte_v[7]}}, byte_v};
    else                  rdata_c = rd_word;
  end

  if (READ_LAT == 1) begin : g_reg_read
    logic [31:0] rdata_q, rdata_d;
    logic        misalign_q, misalign_d;

    always_comb begin
      rdata_d    = reset ? 32'h0 : rdata_c;
      misalign_d = reset ? 1'b0  : misalign_c;
    end

    always_ff @(posedge clk) begin
      rdata_q    <= rdata_d;
      misalign_q <= misalign_d;
    end

    assign bus.rdata    = rdata_q;
    assign bus.misalign = misalign_q;
  end else begin : g_comb_read
    assign bus.rdata    = rdata_c;
    assign bus.misalign = misalign_c;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (TRACE == 1 && store_ok)
      $display("@%h: *%h <= %h", bus.pc, {bus.addr[31:2], 2'b00}, merged);
  end
`endif
endmodule

// File: tb/tb_dm_bytelane.sv
// Drives a combinational-read and a registered-read instance with identical traffic and
// compares both against a byte-array reference model.
module tb_dm_bytelane;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;
  localparam logic [2:0] M_W = 3'b000, M_HU = 3'b001, M_HS = 3'b010, M_BU = 3'b011, M_BS = 3'b100;

  logic clk;
  logic reset;
  dm_bytelane_if b0 ();
  dm_bytelane_if b1 ();

  dm_bytelane #(.ADDR_W(ADDR_W), .READ_LAT(0), .TRACE(1)) u_dut_comb (
    .clk(clk), .reset(reset), .bus(b0)
  );
  dm_bytelane #(.ADDR_W(ADDR_W), .READ_LAT(1), .TRACE(0)) u_dut_reg (
    .clk(clk), .reset(reset), .bus(b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int sweep_left = DEPTH;
  bit started = 0;
  logic [31:0] pc_cnt = 32'h0040_0000;
  logic [7:0] ref_mem [DEPTH*4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int acc_size(input logic [2:0] m);
    case (m)
      M_HU, M_HS: return 2;
      M_BU, M_BS: return 1;
      default:    return 4;
    endcase
  endfunction

  function automatic bit is_mis(input logic [31:0] a, input logic [2:0] m);
    return (int'(a[1:0]) % acc_size(m)) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] m);
    int s = acc_size(m);
    int base = int'(a[5:0]);
    logic [31:0] v = 32'h0;
    for (int i = 0; i < s; i++) v = v | (32'(ref_mem[base+i]) << (8*i));
    if ((m == M_HS || m == M_BS) && v[8*s-1]) v = v | (32'hffff_ffff << (8*s));
    return v;
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] m);
    int s = acc_size(m);
    int base = int'(a[5:0]);
    for (int i = 0; i < s; i++) ref_mem[base+i] = 8'(wd >> (8*i));
  endtask

  // One clock: drive at the falling edge, check combinational outputs, then registered ones after the edge.
  task automatic cyc(input logic rst, input logic [31:0] a, input logic [31:0] wd,
                     input logic w, input logic [2:0] m);
    logic bz, mb;
    logic [31:0] e_rd;
    @(negedge clk);
    reset = rst;
    b0.addr = a;  b0.wdata = wd; b0.we = w; b0.mode = m; b0.pc = pc_cnt;
    b1.addr = a;  b1.wdata = wd; b1.we = w; b1.mode = m; b1.pc = pc_cnt;
    pc_cnt = pc_cnt + 4;
    bz = (sweep_left != 0);
    mb = is_mis(a, m);
    e_rd = (bz || mb) ? 32'h0 : ref_load(a, m);
    #1;
    if (started) begin
      check("comb_busy", {31'b0, b0.busy}, {31'b0, bz});
      check("comb_misalign", {31'b0, b0.misalign}, {31'b0, !bz && mb});
      check("comb_rdata", b0.rdata, e_rd);
    end
    @(posedge clk);
    #1;
    started = 1;
    if (rst) sweep_left = DEPTH;
    else if (bz) begin
      for (int i = 0; i < 4; i++) ref_mem[(DEPTH-sweep_left)*4+i] = 8'h00;
      sweep_left--;
    end else if (w && !mb) ref_store(a, wd, m);
    check("reg_rdata", b1.rdata, rst ? 32'h0 : e_rd);
    check("reg_misalign", {31'b0, b1.misalign}, {31'b0, !rst && !bz && mb});
    check("busy_comb", {31'b0, b0.busy}, {31'b0, sweep_left != 0});
    check("busy_reg", {31'b0, b1.busy}, {31'b0, sweep_left != 0});
  endtask

  task automatic wait_sweep(input string tag, input logic [31:0] st_addr);
    int n = 0;
    do begin
      cyc(1'b0, st_addr, 32'hdead_beef, 1'b1, M_W);
      n++;
    end while (b0.busy && n < 100);
    check(tag, n, DEPTH);
  endtask

  initial begin
    reset = 1'b1;
    b0.addr = '0; b0.wdata = '0; b0.we = 1'b0; b0.mode = M_W; b0.pc = '0;
    b1.addr = '0; b1.wdata = '0; b1.we = 1'b0; b1.mode = M_W; b1.pc = '0;

    // Reset, sweep length, stores ignored while busy, every word clear.
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h0, 32'h0, 1'b0, M_W);
    check("rst_rdata", b1.rdata, 32'h0);
    check("rst_busy", {31'b0, b0.busy}, 32'h1);
    wait_sweep("busy_len_initial", 32'h0);
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b0, 32'(i*4), 32'h0, 1'b0, M_W);
      check("cleared_word", b0.rdata, 32'h0);
    end

    // Word, byte and half stores with extended loads.
    cyc(1'b0, 32'h8, 32'h8bad_f00d, 1'b1, M_W);
    cyc(1'b0, 32'h8, 32'h0, 1'b0, M_W);
    check("lw8", b0.rdata, 32'h8bad_f00d);
    check("lw8_reg", b1.rdata, 32'h8bad_f00d);
    cyc(1'b0, 32'h9, 32'h0000_00f0, 1'b1, M_BU);
    cyc(1'b0, 32'hB, 32'h0, 1'b0, M_BS);
    check("lb_b", b0.rdata, 32'hffff_ff8b);
    cyc(1'b0, 32'hB, 32'h0, 1'b0, M_BU);
    check("lbu_b", b0.rdata, 32'h0000_008b);
    cyc(1'b0, 32'hA, 32'h0000_1234, 1'b1, M_HU);
    cyc(1'b0, 32'h8, 32'h0, 1'b0, M_W);
    check("sh_a_word", b0.rdata, 32'h1234_f00d);
    cyc(1'b0, 32'hA, 32'h0, 1'b0, M_HS);
    check("lh_a", b0.rdata, 32'h0000_1234);
    cyc(1'b0, 32'h4, 32'h0000_8000, 1'b1, M_HS);
    cyc(1'b0, 32'h4, 32'h0, 1'b0, M_HS);
    check("lh_4", b0.rdata, 32'hffff_8000);
    cyc(1'b0, 32'h4, 32'h0, 1'b0, M_HU);
    check("lhu_4", b0.rdata, 32'h0000_8000);

    // Misaligned store is dropped; misaligned load returns zero.
    cyc(1'b0, 32'h6, 32'hffff_ffff, 1'b1, M_W);
    check("sw6_misalign", {31'b0, b0.misalign}, 32'h1);
    cyc(1'b0, 32'h4, 32'h0, 1'b0, M_W);
    check("sw6_no_write", b0.rdata, 32'h0000_8000);
    cyc(1'b0, 32'h3, 32'h0, 1'b0, M_HS);
    check("lh3_misalign", {31'b0, b0.misalign}, 32'h1);
    check("lh3_rdata", b0.rdata, 32'h0);

    // Registered read: same-cycle store is not visible until the following read.
    cyc(1'b0, 32'h8, 32'h0000_0001, 1'b1, M_W);
    check("rbw_old", b1.rdata, 32'h1234_f00d);
    cyc(1'b0, 32'h8, 32'h0, 1'b0, M_W);
    check("rbw_new", b1.rdata, 32'h0000_0001);

    // Random traffic, including upper address bits that must wrap.
    for (int i = 0; i < 400; i++)
      cyc(1'b0, $urandom, $urandom, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));

    // Reset mid-sweep restarts the full sweep.
    cyc(1'b1, 32'h0, 32'h0, 1'b0, M_W);
    for (int i = 0; i < 7; i++) cyc(1'b0, 32'h0, 32'h0, 1'b0, M_W);
    cyc(1'b1, 32'h0, 32'h0, 1'b0, M_W);
    wait_sweep("busy_len_restart", 32'h10);
    for (int i = 0; i < 40; i++)
      cyc(1'b0, $urandom, $urandom, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/dm_bytelane.md
Name: dm_bytelane

Overview:
- Parametrised data memory for the single-cycle/pipelined MIPS datapath.
- Supports word, halfword and byte loads/stores with sign/zero extension on loads.
- Detects misaligned accesses and offers an optional registered read port.
- Clears itself with a sequential sweep after reset, so the array maps to block RAM.
- Emits the standard store trace line on every committed store.

Parameters:
- ADDR_W, 10: log2 of word depth; DEPTH = 2**ADDR_W words of 32 bits.
- READ_LAT, 0: 0 = combinational read, 1 = read data registered one cycle; other values are illegal.
- TRACE, 1: 1 = print the store trace line, 0 = silent.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- addr  in  32  byte address; word index = addr[ADDR_W+1:2]; higher bits are ignored (address wraps).
- wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- we  in  1  store request.
- mode  in  3  000 word, 001 half-unsigned, 010 half-signed, 011 byte-unsigned, 100 byte-signed; 101-111 treated as word.
- pc  in  32  PC of the accessing instruction; used for trace only.
- rdata  out  32  extended load data.
- misalign  out  1  access not aligned to its size.
- busy  out  1  clear sweep in progress.

Behaviour:
- FSM has two states, CLEAR and IDLE, plus a clear pointer clr_ptr of width ADDR_W.
- Reset:
  - Any edge with reset=1 sets state to CLEAR and clr_ptr to 0.
  - Nothing is written to the array while reset is held.
- CLEAR:
  - Each edge with reset=0 writes mem[clr_ptr] to 0 and increments clr_ptr.
  - When clr_ptr==DEPTH-1, the same edge sets state to IDLE.
  - Therefore busy=1 for exactly DEPTH edges after reset deasserts.
  - Reset mid-sweep restarts the sweep at 0.
- While busy:
  - we is ignored and no trace is printed.
  - rdata=0 and misalign=0.
- Alignment:
  - Word accesses require addr[1:0]==0.
  - Half accesses require addr[0]==0.
  - Byte accesses are always aligned.
  - misalign is combinational from addr and mode when READ_LAT=0, and registered alongside rdata when READ_LAT=1.
- Store (IDLE, we=1, aligned):
  - Updates only the addressed lanes at the edge:
    - word writes all four bytes;
    - half writes bytes addr[1]*2 and addr[1]*2+1 from wdata[15:0];
    - byte writes byte addr[1:0] from wdata[7:0].
  - Lane order is little-endian: byte 0 is bits [7:0].
  - A misaligned store is suppressed entirely: no write, no trace.
- Trace:
  - When TRACE=1, a committed store prints "@%h: *%h <= %h".
  - Fields are pc, word-aligned address {addr[31:2],2'b00}, and the full merged 32-bit word after the write.
- Load:
  - The word at the index is selected, then the lane is extracted by addr[1:0] and mode.
  - Sign-extend for modes 010/100, zero-extend for 001/011.
  - A misaligned load returns rdata=0.
  - Loads occur every cycle regardless of we; there is no read-enable.
- READ_LAT=0:
  - rdata is combinational from the array.
  - A same-cycle store to the same word shows the old value until the edge, and the new value afterwards.
- READ_LAT=1:
  - rdata/misalign are registered at the edge from the address presented in the prior cycle.
  - Read-before-write: a same-cycle store does not affect that cycle's registered read.
  - The registers reset to 0 and hold 0 while busy.
- Reset values: rdata=0, misalign=0, busy=1 (from the first edge with reset=1 until the sweep completes).

Test Plan:
1. ADDR_W=4, reset high 3 cycles then low -> busy=1 for exactly 16 further edges, then 0; every word reads 0; a store issued during busy is not committed.
2. After clear, sw 0x8badf00d @0x8 -> lw @0x8 = 0x8badf00d; trace line "@<pc>: *00000008 <= 8badf00d".
3. sb 0x000000f0 @0x9 onto 0x8badf00d -> word = 0x8badf0 0d with byte1=0xf0 (0x8badf00d unchanged lane check); then lb @0xB = 0xffffff8b, lbu @0xB = 0x0000008b.
4. sh 0x00001234 @0xA -> word 0x1234f00d; lh @0xA = 0x00001234; sh 0x8000 @0x4 then lh @0x4 = 0xffff8000, lhu = 0x00008000.
5. sw @0x6 (misaligned) -> misalign=1, memory unchanged, no trace; lh @0x3 -> misalign=1, rdata=0.
6. READ_LAT=1: lw @0x8 in cycle n -> value appears after edge n+1; same-cycle sw 0x1 @0x8 returns the old value, the next read returns 0x1; reset asserted at sweep count 7 -> sweep restarts and busy lasts another DEPTH edges.
